// File: rtl/semafor_pkg.sv
// Shared types and defaults for the semafor traffic-light blocks:
// button-conditioner FSM states, controller phase encoding, default timings.
package semafor_pkg;

    localparam int SEMAFOR_DEBOUNCE_DEF = 1000;
    localparam int SEMAFOR_LOCKOUT_DEF  = 30;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        LOCK = 2'b10
    } btn_state_t;

    typedef enum logic [1:0] {
        PH_CAR_GREEN  = 2'b00,
        PH_CAR_YELLOW = 2'b01,
        PH_PED_GREEN  = 2'b10,
        PH_ALL_RED    = 2'b11
    } semafor_phase_t;

    // A counter for n states still needs at least one bit when n is 1.
    function automatic int cntWidth(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/semafor_btn_req_if.sv
// Button-request bundle between the raw push-button side, the conditioner
// and the traffic-light controller.
interface semafor_btn_req_if;

    logic btn_raw;
    logic req_ack;
    logic btn_req;
    logic btn_pressed;
    logic btn_level;
    logic lockout;

    modport master (
        output btn_raw,
        output req_ack,
        input  btn_req,
        input  btn_pressed,
        input  btn_level,
        input  lockout
    );

    modport slave (
        input  btn_raw,
        input  req_ack,
        output btn_req,
        output btn_pressed,
        output btn_level,
        output lockout
    );

endinterface

// File: rtl/semafor_sync2.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs,
// asynchronous active-low reset.
module semafor_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/semafor_btn_req.sv
// Pedestrian push-button conditioner: synchronise, debounce, edge-detect and
// hold one request until acknowledged. Optional lockout: SEMAFOR_BTN_LOCKOUT_EN.
module semafor_btn_req
    import semafor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SEMAFOR_DEBOUNCE_DEF,
    parameter int LOCKOUT_CYCLES  = SEMAFOR_LOCKOUT_DEF
) (
    input logic              clk,
    input logic              rst_n,
    semafor_btn_req_if.slave bus
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LOCKOUT_CYCLES < 1) begin : g_badParams
        $error("semafor_btn_req: DEBOUNCE_CYCLES must be >= 2, LOCKOUT_CYCLES >= 1");
    end

    logic             btnSync;
    logic             btnLevel_q, btnLevel_d;
    logic [DEB_W-1:0] debCnt_q, debCnt_d;
    logic             levelPrev_q;
    logic             pressed_q;
    logic             rise;
    btn_state_t       state_q, state_d;

    semafor_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.btn_raw),
        .q_o   (btnSync)
    );

    // Any cycle where sync agrees with the accepted level restarts the count.
    always_comb begin
        btnLevel_d = btnLevel_q;
        debCnt_d   = '0;
        if (btnSync != btnLevel_q) begin
            if (debCnt_q == DEB_MAX) begin
                btnLevel_d = btnSync;
            end else begin
                debCnt_d = debCnt_q + DEB_W'(1);
            end
        end
    end

    assign rise = btnLevel_q & ~levelPrev_q;

`ifdef SEMAFOR_BTN_LOCKOUT_EN
    localparam int LOCK_W = cntWidth(LOCKOUT_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCKOUT_CYCLES - 1);

    logic [LOCK_W-1:0] lockCnt_q, lockCnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lockCnt_q <= '0;
        end else begin
            lockCnt_q <= lockCnt_d;
        end
    end
`endif

    // The ack in REQ takes priority over a coincident press, which is dropped.
    always_comb begin
        state_d = state_q;
`ifdef SEMAFOR_BTN_LOCKOUT_EN
        lockCnt_d = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.req_ack) begin
`ifdef SEMAFOR_BTN_LOCKOUT_EN
                    state_d = LOCK;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef SEMAFOR_BTN_LOCKOUT_EN
            LOCK: begin
                if (lockCnt_q == LOCK_MAX) begin
                    state_d = IDLE;
                end else begin
                    lockCnt_d = lockCnt_q + LOCK_W'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btnLevel_q  <= 1'b0;
            debCnt_q    <= '0;
            levelPrev_q <= 1'b0;
            pressed_q   <= 1'b0;
            state_q     <= IDLE;
        end else begin
            btnLevel_q  <= btnLevel_d;
            debCnt_q    <= debCnt_d;
            levelPrev_q <= btnLevel_q;
            pressed_q   <= rise;
            state_q     <= state_d;
        end
    end

    assign bus.btn_req     = (state_q == REQ);
    assign bus.btn_pressed = pressed_q;
    assign bus.btn_level   = btnLevel_q;
`ifdef SEMAFOR_BTN_LOCKOUT_EN
    assign bus.lockout     = (state_q == LOCK);
`else
    assign bus.lockout     = 1'b0;
`endif

endmodule

// File: tb/tb_semafor_btn_req.sv
// Self-checking bench for semafor_btn_req against a history-based reference
// model; honours SEMAFOR_BTN_LOCKOUT_EN the same way as the design.
module tb_semafor_btn_req;

    localparam int DEB    = 4;
    localparam int LOCK_N = 8;
`ifdef SEMAFOR_BTN_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    semafor_btn_req_if bus ();

    semafor_btn_req #(
        .DEBOUNCE_CYCLES (DEB),
        .LOCKOUT_CYCLES  (LOCK_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: raw samples, sync samples seen by the debouncer,
    // accepted level, pending press, held request, remaining lockout cycles.
    logic rawHist[$];
    logic syncHist[$];
    logic mLevel, mPressed, mReq, pressDue;
    int   lockLeft;

    task automatic modelReset();
        rawHist.delete();
        syncHist.delete();
        mLevel = 1'b0; mPressed = 1'b0; mReq = 1'b0; pressDue = 1'b0;
        lockLeft = 0;
    endtask

    task automatic modelEdge();
        logic syncNow, allDiff;
        syncNow = (rawHist.size() >= 2) ? rawHist[rawHist.size()-2] : 1'b0;
        rawHist.push_back(bus.btn_raw);
        if (rawHist.size() > 3) rawHist.delete(0);
        mPressed = pressDue;
        if (mReq) begin
            if (bus.req_ack) begin
                mReq = 1'b0;
                lockLeft = LOCK_EN ? LOCK_N : 0;
            end
        end else if (lockLeft > 0) begin
            lockLeft--;
        end else if (pressDue) begin
            mReq = 1'b1;
        end
        syncHist.push_back(syncNow);
        if (syncHist.size() > DEB) syncHist.delete(0);
        allDiff = (syncHist.size() == DEB);
        foreach (syncHist[i]) if (syncHist[i] == mLevel) allDiff = 1'b0;
        pressDue = allDiff && !mLevel;
        if (allDiff) mLevel = !mLevel;
    endtask

    function automatic logic [3:0] expVec();
        return {mReq, mPressed, mLevel, (lockLeft > 0)};
    endfunction

    function automatic logic [3:0] obsVec();
        return {bus.btn_req, bus.btn_pressed, bus.btn_level, bus.lockout};
    endfunction

    task automatic step(input logic raw, input logic ack);
        bus.btn_raw = raw;
        bus.req_ack = ack;
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic settle();
        for (int i = 0; i < DEB + 4; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < LOCK_N + 4; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        bus.btn_raw = 1'b0;
        bus.req_ack = 1'b0;
        rst_n = 1'b0;
        #12;
        vectors++;
        if (obsVec() !== 4'b0000) begin
            $display("[TB] FAIL reset_outputs: got %b expected 0000", obsVec());
            miscompares++;
        end
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic test_clean_press();
        int firstLevel, firstReq, pulses;
        firstLevel = -1; firstReq = -1; pulses = 0;
        for (int e = 1; e <= 10; e++) begin
            step(1'b1, 1'b0);
            vectors++;
            if (obsVec() !== expVec()) begin
                $display("[TB] FAIL clean_press edge %0d: got %b expected %b", e, obsVec(), expVec());
                miscompares++;
            end
            if (bus.btn_level === 1'b1 && firstLevel < 0) firstLevel = e;
            if (bus.btn_req === 1'b1 && firstReq < 0) firstReq = e;
            if (bus.btn_pressed === 1'b1) pulses++;
        end
        vectors++;
        if (firstLevel !== 6 || firstReq !== 7 || pulses !== 1) begin
            $display("[TB] FAIL clean_press_latency: level@%0d req@%0d pulses %0d, expected 6 7 1",
                     firstLevel, firstReq, pulses);
            miscompares++;
        end
        settle();
    endtask

    task automatic test_bounce();
        logic seq [16];
        int pulseIdx, pulses;
        pulseIdx = -1; pulses = 0;
        foreach (seq[i]) seq[i] = (i < 4) ? ((i % 2) == 0) : 1'b1;
        foreach (seq[i]) begin
            step(seq[i], 1'b0);
            vectors++;
            if (obsVec() !== expVec()) begin
                $display("[TB] FAIL bounce idx %0d: got %b expected %b", i + 1, obsVec(), expVec());
                miscompares++;
            end
            if (bus.btn_pressed === 1'b1) begin
                pulses++;
                pulseIdx = i + 1;
            end
        end
        vectors++;
        if (pulses !== 1 || pulseIdx !== 11) begin
            $display("[TB] FAIL bounce_pulse: %0d pulses at edge %0d, expected 1 at 11", pulses, pulseIdx);
            miscompares++;
        end
        settle();
    endtask

    task automatic test_multi_press();
        int pulses, reqDrops;
        pulses = 0; reqDrops = 0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 16; i++) begin
                step(i < 8, 1'b0);
                vectors++;
                if (obsVec() !== expVec()) begin
                    $display("[TB] FAIL multi_press p%0d i%0d: got %b expected %b", p, i, obsVec(), expVec());
                    miscompares++;
                end
                if (bus.btn_pressed === 1'b1) pulses++;
                if (!(p == 0 && i < 7) && bus.btn_req !== 1'b1) reqDrops++;
            end
        end
        step(1'b0, 1'b1);
        vectors++;
        if (pulses !== 3 || reqDrops !== 0 || bus.btn_req !== 1'b0) begin
            $display("[TB] FAIL multi_press_ack: pulses %0d drops %0d req %b, expected 3 0 0",
                     pulses, reqDrops, bus.btn_req);
            miscompares++;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            vectors++;
            if (obsVec() !== expVec()) begin
                $display("[TB] FAIL multi_press_after i%0d: got %b expected %b", i, obsVec(), expVec());
                miscompares++;
            end
        end
    endtask

    task automatic test_ack_press_same();
        for (int i = 0; i < 16; i++) step(i < 8, 1'b0);
        for (int i = 1; i <= 27; i++) begin
            step(1'b1, i == 7);
            vectors++;
            if (obsVec() !== expVec()) begin
                $display("[TB] FAIL ack_press_same edge %0d: got %b expected %b", i, obsVec(), expVec());
                miscompares++;
            end
            if (i == 7) begin
                vectors++;
                if (bus.btn_req !== 1'b0 || bus.btn_pressed !== 1'b1) begin
                    $display("[TB] FAIL ack_wins: req %b pressed %b, expected 0 1", bus.btn_req, bus.btn_pressed);
                    miscompares++;
                end
            end
            if (i > 7 && bus.btn_req !== 1'b0) begin
                vectors++;
                $display("[TB] FAIL held_no_rerequest edge %0d: req %b expected 0", i, bus.btn_req);
                miscompares++;
            end
        end
        settle();
    endtask

    task automatic test_lockout();
        for (int i = 0; i < 16; i++) step(i < 8, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, i == 4);
            vectors++;
            if (obsVec() !== expVec()) begin
                $display("[TB] FAIL lockout edge %0d: got %b expected %b", i, obsVec(), expVec());
                miscompares++;
            end
        end
        vectors++;
        if (bus.btn_pressed !== 1'b1 || bus.btn_req !== !LOCK_EN || bus.lockout !== LOCK_EN) begin
            $display("[TB] FAIL lockout_press: pressed %b req %b lockout %b, expected 1 %b %b",
                     bus.btn_pressed, bus.btn_req, bus.lockout, !LOCK_EN, LOCK_EN);
            miscompares++;
        end
        for (int i = 0; i < 28; i++) begin
            step((i >= 12 && i < 20) || (!LOCK_EN && i < 12), 1'b0);
            vectors++;
            if (obsVec() !== expVec()) begin
                $display("[TB] FAIL lockout_after i%0d: got %b expected %b", i, obsVec(), expVec());
                miscompares++;
            end
        end
        vectors++;
        if (bus.btn_req !== 1'b1 || bus.lockout !== 1'b0) begin
            $display("[TB] FAIL lockout_repress: req %b lockout %b, expected 1 0", bus.btn_req, bus.lockout);
            miscompares++;
        end
        settle();
    endtask

    task automatic test_reset_mid();
        int firstReq;
        firstReq = -1;
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obsVec() !== 4'b0000) begin
            $display("[TB] FAIL reset_async: got %b expected 0000", obsVec());
            miscompares++;
        end
        bus.btn_raw = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        for (int e = 1; e <= 10; e++) begin
            step(1'b1, 1'b0);
            vectors++;
            if (obsVec() !== expVec()) begin
                $display("[TB] FAIL reset_repress edge %0d: got %b expected %b", e, obsVec(), expVec());
                miscompares++;
            end
            if (bus.btn_req === 1'b1 && firstReq < 0) firstReq = e;
        end
        vectors++;
        if (firstReq !== 7) begin
            $display("[TB] FAIL reset_repress_latency: req at edge %0d expected 7", firstReq);
            miscompares++;
        end
        settle();
    endtask

    task automatic test_random();
        logic raw;
        int hold;
        raw = 1'b0;
        hold = 0;
        for (int i = 0; i < 1200; i++) begin
            if (hold == 0) begin
                raw = $urandom_range(0, 1);
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
            end
            hold--;
            step(raw, $urandom_range(0, 11) == 0);
            vectors++;
            if (obsVec() !== expVec()) begin
                $display("[TB] FAIL random cycle %0d: got %b expected %b", i, obsVec(), expVec());
                miscompares++;
            end
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_press();
        test_ack_press_same();
        test_lockout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
